// File: rtl/mc_array_pkg.sv
// Shared types and constants for the memory-controller array responder.
// FSM encoding, error-bit positions and counter widths used by the top and the bench.
package mc_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RCD    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_RP     = 2'd3
    } state_e;

    localparam int ERR_W        = 6;
    localparam int ERR_CAS_IDLE = 0;
    localparam int ERR_TRCD     = 1;
    localparam int ERR_TRP      = 2;
    localparam int ERR_NO_WDATA = 3;
    localparam int ERR_WR_RD    = 4;
    localparam int ERR_RADDR    = 5;

    localparam int CNT_W = 16;
    localparam int TMR_W = 8;

endpackage

// File: rtl/mc_array_rd_pipe.sv
// Read-data delay line: RD_LAT stages of valid/data, synchronously flushed.
// Latency RD_LAT cycles; no backpressure, output data holds when no valid arrives.
module mc_array_rd_pipe #(
    parameter int RD_LAT     = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  flush_i,
    input  logic                  in_vld_i,
    input  logic [DATA_WIDTH-1:0] in_dat_i,
    output logic                  out_vld_o,
    output logic [DATA_WIDTH-1:0] out_dat_o
);

    logic [RD_LAT-1:0]     vld_q;
    logic [DATA_WIDTH-1:0] dat_q [RD_LAT];

    // Each stage only loads when a valid word moves into it, so the last
    // stage naturally holds its previous value between reads.
    always_ff @(posedge clk) begin
        if (flush_i) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld_i;
            if (in_vld_i) begin
                dat_q[0] <= in_dat_i;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_vld_o = vld_q[RD_LAT-1];
    assign out_dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/mc_array_resp.sv
// Array-side responder: decodes activate/CAS commands, stores data, returns reads, flags violations.
// Read latency RD_LAT cycles; no backpressure, every legal command is accepted in the cycle it appears.
module mc_array_resp
    import mc_array_pkg::*;
#(
    parameter int RADDR_WIDTH = 14,
    parameter int CADDR_WIDTH = 6,
    parameter int DATA_WIDTH  = 64,
    parameter int ROW_BITS    = 2,
    parameter int RD_LAT      = 2,
    parameter int T_RCD       = 6,
    parameter int T_RP        = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   array_banksel_n,
    input  logic [RADDR_WIDTH-1:0] array_raddr,
    input  logic                   array_cas_wr,
    input  logic [CADDR_WIDTH-1:0] array_caddr_wr,
    input  logic                   array_wdata_rdy,
    input  logic [DATA_WIDTH-1:0]  array_wdata,
    input  logic                   array_cas_rd,
    input  logic [CADDR_WIDTH-1:0] array_caddr_rd,
    output logic                   array_rdata_rdy,
    output logic [DATA_WIDTH-1:0]  array_rdata,
    input  logic                   err_clr,
    output logic [ERR_W-1:0]       err_flags,
    output logic [CNT_W-1:0]       wr_cnt,
    output logic [CNT_W-1:0]       rd_cnt
);

    localparam int ADDR_W = ROW_BITS + CADDR_WIDTH;

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [ROW_BITS-1:0]    row_q, row_d;
    logic [RADDR_WIDTH-1:0] act_raddr_q, act_raddr_d;
    logic                   bsel_n_q;
    logic [ERR_W-1:0]       err_q, err_d, err_new;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0]  mem_q [2**ADDR_W];

    logic act_fall, act_rise, in_act, in_rcd, cas_any, wr_acc, rd_acc, trp_viol;

    assign act_fall = bsel_n_q & ~array_banksel_n;
    assign act_rise = ~bsel_n_q & array_banksel_n;
    assign in_act   = (state_q == ST_ACTIVE);
    assign in_rcd   = (state_q == ST_RCD);
    assign cas_any  = array_cas_wr | array_cas_rd;
    assign wr_acc   = ~rst & in_act & array_cas_wr & array_wdata_rdy;
    // A simultaneous write wins; the read is dropped.
    assign rd_acc   = ~rst & in_act & array_cas_rd & ~array_cas_wr;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        row_d       = row_q;
        act_raddr_d = act_raddr_q;
        trp_viol    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (act_fall) begin
                    row_d       = array_raddr[ROW_BITS-1:0];
                    act_raddr_d = array_raddr;
                    if (T_RCD == 0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_RCD;
                        tmr_d   = TMR_W'(T_RCD - 1);
                    end
                end
            end
            ST_RCD: begin
                if (act_rise) begin
                    state_d = (T_RP == 0) ? ST_IDLE : ST_RP;
                    tmr_d   = TMR_W'(T_RP - 1);
                end else if (tmr_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (act_rise) begin
                    state_d = (T_RP == 0) ? ST_IDLE : ST_RP;
                    tmr_d   = TMR_W'(T_RP - 1);
                end
            end
            ST_RP: begin
                trp_viol = act_fall;
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_new                = '0;
        err_new[ERR_CAS_IDLE]  = cas_any & ~in_act & ~in_rcd;
        err_new[ERR_TRCD]      = cas_any & in_rcd;
        err_new[ERR_TRP]       = trp_viol;
        err_new[ERR_NO_WDATA]  = array_cas_wr & ~array_wdata_rdy;
        err_new[ERR_WR_RD]     = array_cas_wr & array_cas_rd;
        err_new[ERR_RADDR]     = in_act & (array_raddr != act_raddr_q);
        // Clear first, then OR in this cycle's events so a fresh error survives err_clr.
        err_d    = (err_clr ? '0 : err_q) | err_new;
        wr_cnt_d = wr_cnt_q + CNT_W'(wr_acc);
        rd_cnt_d = rd_cnt_q + CNT_W'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            row_q       <= '0;
            act_raddr_q <= '0;
            bsel_n_q    <= 1'b1;
            err_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            row_q       <= row_d;
            act_raddr_q <= act_raddr_d;
            bsel_n_q    <= array_banksel_n;
            err_q       <= err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // Storage deliberately survives reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[{row_q, array_caddr_wr}] <= array_wdata;
        end
    end

    mc_array_rd_pipe #(
        .RD_LAT     (RD_LAT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk       (clk),
        .flush_i   (rst),
        .in_vld_i  (rd_acc),
        .in_dat_i  (mem_q[{row_q, array_caddr_rd}]),
        .out_vld_o (array_rdata_rdy),
        .out_dat_o (array_rdata)
    );

    assign err_flags = err_q;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_mc_array_resp.sv
// Directed bench for mc_array_resp: activation timing, read latency, error flags, reset behaviour.
module tb_mc_array_resp;
    import mc_array_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        bsel_n;
    logic [13:0] raddr;
    logic        cas_wr, wrdy, cas_rd, err_clr;
    logic [5:0]  caddr_wr, caddr_rd;
    logic [63:0] wdata;
    logic        rdata_rdy;
    logic [63:0] rdata;
    logic [5:0]  err_flags;
    logic [15:0] wr_cnt, rd_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    mc_array_resp dut (
        .clk             (clk),
        .rst             (rst),
        .array_banksel_n (bsel_n),
        .array_raddr     (raddr),
        .array_cas_wr    (cas_wr),
        .array_caddr_wr  (caddr_wr),
        .array_wdata_rdy (wrdy),
        .array_wdata     (wdata),
        .array_cas_rd    (cas_rd),
        .array_caddr_rd  (caddr_rd),
        .array_rdata_rdy (rdata_rdy),
        .array_rdata     (rdata),
        .err_clr         (err_clr),
        .err_flags       (err_flags),
        .wr_cnt          (wr_cnt),
        .rd_cnt          (rd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; bsel_n = 1'b1; raddr = '0;
        cas_wr = 1'b0; wrdy = 1'b0; caddr_wr = '0; wdata = '0;
        cas_rd = 1'b0; caddr_rd = '0; err_clr = 1'b0;
        step(3);
        chk("rst_rdy", 64'(rdata_rdy), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_err", 64'(err_flags), 64'd0);
        chk("rst_wrcnt", 64'(wr_cnt), 64'd0);
        chk("rst_rdcnt", 64'(rd_cnt), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        rst = 1'b0;

        // Activate row 0x3F2 (stored row 2), wait out T_RCD, write cols 0..3.
        raddr = 14'h3F2; bsel_n = 1'b0;
        step();
        chk("act_rcd", 64'(dut.state_q), 64'(ST_RCD));
        step(6);
        chk("act_active", 64'(dut.state_q), 64'(ST_ACTIVE));
        for (int i = 0; i < 4; i++) begin
            cas_wr = 1'b1; wrdy = 1'b1; caddr_wr = 6'(i); wdata = 64'h1010 + 64'(i);
            step();
        end
        cas_wr = 1'b0; wrdy = 1'b0;
        cas_rd = 1'b1; caddr_rd = 6'd2;
        step();
        cas_rd = 1'b0;
        chk("rd_lat_early", 64'(rdata_rdy), 64'd0);
        step();
        chk("rd_lat_rdy", 64'(rdata_rdy), 64'd1);
        chk("rd_lat_data", rdata, 64'h1012);
        chk("wrcnt4", 64'(wr_cnt), 64'd4);
        chk("rdcnt1", 64'(rd_cnt), 64'd1);
        chk("err_clean", 64'(err_flags), 64'd0);
        step();
        chk("rd_one_cycle", 64'(rdata_rdy), 64'd0);
        chk("rd_hold", rdata, 64'h1012);

        // Back-to-back reads of cols 0..3.
        for (int i = 0; i < 4; i++) begin
            cas_rd = 1'b1; caddr_rd = 6'(i);
            step();
            if (i >= 1) begin
                chk("b2b_rdy", 64'(rdata_rdy), 64'd1);
                chk("b2b_data", rdata, 64'h1010 + 64'(i - 1));
            end
        end
        cas_rd = 1'b0;
        step();
        chk("b2b_last_rdy", 64'(rdata_rdy), 64'd1);
        chk("b2b_last_data", rdata, 64'h1013);
        step();
        chk("b2b_end", 64'(rdata_rdy), 64'd0);
        chk("rdcnt5", 64'(rd_cnt), 64'd5);

        // Write and read together on col 5: write lands, read dropped.
        cas_wr = 1'b1; wrdy = 1'b1; caddr_wr = 6'd5; wdata = 64'hABCD;
        cas_rd = 1'b1; caddr_rd = 6'd5;
        step();
        cas_wr = 1'b0; wrdy = 1'b0; cas_rd = 1'b0;
        chk("wrrd_err", 64'(err_flags), 64'h10);
        step();
        chk("wrrd_no_rdy_a", 64'(rdata_rdy), 64'd0);
        step();
        chk("wrrd_no_rdy_b", 64'(rdata_rdy), 64'd0);
        chk("wrrd_wrcnt", 64'(wr_cnt), 64'd5);
        chk("wrrd_rdcnt", 64'(rd_cnt), 64'd5);
        cas_rd = 1'b1; caddr_rd = 6'd5;
        step();
        cas_rd = 1'b0;
        step();
        chk("col5_rdy", 64'(rdata_rdy), 64'd1);
        chk("col5_data", rdata, 64'hABCD);

        // err_clr coincident with a new write-without-data error: new bit survives.
        err_clr = 1'b1; cas_wr = 1'b1; wrdy = 1'b0; caddr_wr = 6'd6;
        step();
        err_clr = 1'b0; cas_wr = 1'b0;
        chk("clr_vs_new", 64'(err_flags), 64'h08);
        chk("nowdata_wrcnt", 64'(wr_cnt), 64'd5);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_all", 64'(err_flags), 64'd0);

        // Precharge, then re-activate too early.
        bsel_n = 1'b1;
        step();
        chk("pre_rp", 64'(dut.state_q), 64'(ST_RP));
        step(2);
        bsel_n = 1'b0;
        step();
        chk("trp_err", 64'(err_flags), 64'h04);
        chk("trp_stay_rp", 64'(dut.state_q), 64'(ST_RP));
        bsel_n = 1'b1; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("trp_clr", 64'(err_flags), 64'd0);
        step(3);
        chk("rp_to_idle", 64'(dut.state_q), 64'(ST_IDLE));
        bsel_n = 1'b0;
        step();
        chk("react_rcd", 64'(dut.state_q), 64'(ST_RCD));
        chk("react_noerr", 64'(err_flags), 64'd0);

        // CAS during T_RCD is dropped.
        step(2);
        cas_wr = 1'b1; wrdy = 1'b1; caddr_wr = 6'd0; wdata = 64'hDEAD;
        step();
        cas_wr = 1'b0; wrdy = 1'b0;
        chk("trcd_err", 64'(err_flags), 64'h02);
        chk("trcd_wrcnt", 64'(wr_cnt), 64'd5);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("trcd_clr", 64'(err_flags), 64'd0);
        step(2);
        chk("trcd_active", 64'(dut.state_q), 64'(ST_ACTIVE));
        cas_rd = 1'b1; caddr_rd = 6'd0;
        step();
        cas_rd = 1'b0;
        step();
        chk("col0_kept", rdata, 64'h1010);

        // Row aliasing: 0x006 maps to the same stored row as 0x3F2.
        bsel_n = 1'b1;
        step(8);
        raddr = 14'h006; bsel_n = 1'b0;
        step(7);
        cas_rd = 1'b1; caddr_rd = 6'd3;
        step();
        cas_rd = 1'b0;
        step();
        chk("alias_rdy", 64'(rdata_rdy), 64'd1);
        chk("alias_data", rdata, 64'h1013);
        raddr = 14'h007;
        step();
        chk("raddr_err", 64'(err_flags), 64'h20);
        raddr = 14'h006; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("raddr_clr", 64'(err_flags), 64'd0);

        // Reset with a read in flight.
        cas_rd = 1'b1; caddr_rd = 6'd3;
        step();
        cas_rd = 1'b0; rst = 1'b1; bsel_n = 1'b1;
        step();
        chk("rstrd_rdy_a", 64'(rdata_rdy), 64'd0);
        chk("rstrd_rdata", rdata, 64'd0);
        rst = 1'b0;
        step();
        chk("rstrd_rdy_b", 64'(rdata_rdy), 64'd0);
        chk("rstrd_rdcnt", 64'(rd_cnt), 64'd0);
        chk("rstrd_wrcnt", 64'(wr_cnt), 64'd0);
        chk("rstrd_state", 64'(dut.state_q), 64'(ST_IDLE));

        // CAS with bank closed.
        cas_rd = 1'b1; caddr_rd = 6'd0;
        step();
        cas_rd = 1'b0;
        chk("idle_cas_err", 64'(err_flags), 64'h01);
        step();
        chk("idle_cas_rdy", 64'(rdata_rdy), 64'd0);
        chk("idle_cas_rdcnt", 64'(rd_cnt), 64'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Storage retained across reset.
        bsel_n = 1'b0;
        step(7);
        cas_rd = 1'b1; caddr_rd = 6'd1;
        step();
        cas_rd = 1'b0;
        step();
        chk("retain_rdy", 64'(rdata_rdy), 64'd1);
        chk("retain_data", rdata, 64'h1011);
        chk("retain_rdcnt", 64'(rd_cnt), 64'd1);
        chk("final_err", 64'(err_flags), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_array_resp.md
# mc_array_resp

Cycle-accurate responder for the memory-controller array interface: the array-side counterpart of `mc_top`. It decodes row activation, column write and column read commands, and stores write data in a small synthesizable array. It returns read data after a fixed latency and flags protocol or timing violations. It is used as the array stub in `mc_top` benches and as an FPGA bring-up target.

## Interface
Parameters:
- `RADDR_WIDTH`, default 14: row address width.
- `CADDR_WIDTH`, default 6: column address width; 2^CADDR_WIDTH columns per row.
- `DATA_WIDTH`, default 64: data word width.
- `ROW_BITS`, default 2: low row-address bits that index storage (2^ROW_BITS rows stored).
- `RD_LAT`, default 2: cycles from `array_cas_rd` to `array_rdata_rdy`; legal range 1..8.
- `T_RCD`, default 6: minimum cycles from activation to the first CAS.
- `T_RP`, default 7: minimum cycles from precharge to the next activation.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `array_banksel_n` in 1: low = row open; a high-to-low transition is an activation.
- `array_raddr` in RADDR_WIDTH: row address, sampled on activation.
- `array_cas_wr` in 1: column write strobe.
- `array_caddr_wr` in CADDR_WIDTH: write column.
- `array_wdata_rdy` in 1: write data valid.
- `array_wdata` in DATA_WIDTH: write data.
- `array_cas_rd` in 1: column read strobe.
- `array_caddr_rd` in CADDR_WIDTH: read column.
- `array_rdata_rdy` out 1: read data valid, one cycle per read.
- `array_rdata` out DATA_WIDTH: read data.
- `err_clr` in 1: clears `err_flags`.
- `err_flags` out 6: sticky error bits.
- `wr_cnt` out 16: accepted writes; wraps at 16 bits.
- `rd_cnt` out 16: accepted reads; wraps at 16 bits.

## Operation
- FSM states: IDLE (bank closed), RCD (opening, counting T_RCD), ACTIVE (row open), RP (precharging, counting T_RP).
- IDLE: `banksel_n` falls → latch `raddr[ROW_BITS-1:0]` as the open row; go to RCD with the counter loaded to T_RCD-1. If T_RCD=0, go straight to ACTIVE.
- RCD: counter reaches 0 → ACTIVE.
- ACTIVE: `banksel_n` rises → RP, counter loaded to T_RP-1.
- RP: counter reaches 0 → IDLE.
- `banksel_n` rising in RCD → RP; no error is raised.
- Write accept condition: `cas_wr && wdata_rdy` in ACTIVE → `mem[row][caddr_wr] <= wdata`; `wr_cnt` increments.
- Read accept condition: `cas_rd` in ACTIVE → the word is captured into the read pipe; `rd_cnt` increments.
- A rejected command has no storage effect and does not change the counters.
- `err_flags` bits, each set on its event and held until cleared:
  - [0] CAS outside RCD/ACTIVE.
  - [1] CAS in RCD (T_RCD violation); the command is dropped.
  - [2] `banksel_n` falls in RP (T_RP violation); the activation is ignored and the FSM stays in RP.
  - [3] `cas_wr` without `wdata_rdy`; the write is dropped.
  - [4] `cas_wr` and `cas_rd` in the same cycle; the write is performed and the read is dropped.
  - [5] `raddr` changes while in ACTIVE.
- `err_clr` clears all flags. A new error in the same cycle as `err_clr` wins and its bit stays set.
- Row aliasing: upper row-address bits are ignored; rows 0x004 and 0x000 hit the same storage.

## Timing
- Reset values: `array_rdata_rdy`=0, `array_rdata`=0, `err_flags`=0, `wr_cnt`=0, `rd_cnt`=0, FSM=IDLE, read pipe flushed.
- Storage is not cleared by reset.
- Reset mid-burst: in-flight reads are discarded, so no `rdata_rdy` appears after reset is asserted.
- Read latency: `cas_rd` in cycle N → `rdata_rdy`=1 with data in cycle N+RD_LAT.
- Back-to-back reads, one per cycle, give consecutive `rdata_rdy` cycles.
- `array_rdata` holds its last value when `rdata_rdy`=0.
- Read data is sampled from storage in cycle N. A write accepted in cycle N is not visible to a read in cycle N; that case is flagged as err[4] anyway. A write accepted in N is visible to a read in N+1.
- Precharge while reads are in flight: the queued data is still returned on schedule.
- All outputs are registered.

## Structure
- Package `mc_array_pkg`:
  - FSM state enum.
  - `ERR_*` bit-index constants.
  - Counter width constant `CNT_W=16`.
- Sub-module `mc_array_rd_pipe`: RD_LAT-deep valid/data shift register with synchronous flush.
- Storage is a plain register array indexed `{row, caddr}`.

## Test plan
- Activate raddr 0x3F2, wait 6 cycles, write cols 0..3 with data 1010..1013, then `cas_rd` col 2 → `rdata_rdy` 2 cycles later with 1012; `wr_cnt`=4, `rd_cnt`=1, `err_flags`=0.
- Activate, then `cas_wr` 3 cycles later → `err_flags[1]`=1, no write, `wr_cnt` unchanged. Pulse `err_clr` → `err_flags`=0.
- Read cols 0..3 back-to-back → four consecutive `rdata_rdy` cycles with 1010, 1011, 1012, 1013.
- Precharge, re-activate after 3 cycles → `err_flags[2]`=1 and state stays RP. Re-activate after 7 cycles → ACTIVE, no new error.
- `cas_wr`+`cas_rd` in the same cycle, col 5, data 0xABCD → `err_flags[4]`=1, no `rdata_rdy`; a later read of col 5 returns 0xABCD.
- Issue a read, assert `rst` the next cycle → no `rdata_rdy`; a read after reset of a previously written column returns the old data (storage retained).
